// File: rtl/game_pkg.sv
// Purpose : shared constants, state codes and platform geometry for the platformer.
// Latency : n/a (package only).
// Backpressure: n/a. The renderer imports this package as well.
package game_pkg;

    // Game state codes, carried to the renderer as S.
    typedef enum logic [2:0] {
        GAME_MENU = 3'b000,
        GAME_ON   = 3'b001,
        GAME_LOSE = 3'b010,
        GAME_WIN  = 3'b011
    } game_state_e;

    // Playfield extent and lava surface. Geometry is 11-bit signed so that
    // clamp and overflow compares cannot wrap.
    localparam logic signed [10:0] WIDTH    = 11'sd640;
    localparam logic signed [10:0] HEIGHT   = 11'sd480;
    localparam logic signed [10:0] LAVA_LVL = 11'sd440;

    // A platform spans x in [x_start, x_end). Its top surface is at plat_y.
    typedef struct packed {
        logic signed [10:0] x_start;
        logic signed [10:0] x_end;
        logic signed [10:0] plat_y;
    } plat_t;

    localparam int NUM_PLATS = 3;

    localparam plat_t PLAT1 = '{x_start: 11'sd50,  x_end: 11'sd200, plat_y: 11'sd425};
    localparam plat_t PLAT2 = '{x_start: 11'sd250, x_end: 11'sd350, plat_y: 11'sd375};
    localparam plat_t PLAT3 = '{x_start: 11'sd400, x_end: 11'sd550, plat_y: 11'sd425};

    // Index 0 is platform 1. Index 2 is the goal platform.
    localparam plat_t [NUM_PLATS-1:0] PLATS = {PLAT3, PLAT2, PLAT1};

    // True when a sprite of width w at left edge x shares a column with p.
    function automatic logic x_overlap(input logic signed [10:0] x,
                                       input logic signed [10:0] w,
                                       input plat_t              p);
        return ((x + w) > p.x_start) && (x < p.x_end);
    endfunction

endpackage

// File: rtl/game_controller_if.sv
// Purpose : groups the button, pixel-coordinate and renderer-facing signals of the game controller.
// Latency : n/a (wiring only).
// Backpressure: none. Buttons are levels, frame_tick is a pulse, and the outputs are always valid.
// Ports   : master = stimulus/board side, drives the inputs. slave = game_controller.
interface game_controller_if;
    logic       frame_tick;
    logic       btn_start;
    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic [9:0] x_coord;
    logic [9:0] y_coord;
    logic [2:0] S;
    logic [9:0] char_x;
    logic [9:0] char_y;
    logic       in_char;

    modport master (
        output frame_tick, btn_start, btn_left, btn_right, btn_jump, x_coord, y_coord,
        input  S, char_x, char_y, in_char
    );

    modport slave (
        input  frame_tick, btn_start, btn_left, btn_right, btn_jump, x_coord, y_coord,
        output S, char_x, char_y, in_char
    );
endinterface

// File: rtl/player_physics.sv
// Purpose : one frame of player motion: walk, jump/gravity, platform landing, ceiling, and the lava/win flags.
// Latency : purely combinational. The caller registers the results on frame_tick.
// Backpressure: none.
// Ports   : x_i/y_i/vel_i current state. left_i/right_i/jump_i buttons.
//           x_o/y_o/vel_o next state. lava_o/win_o are the outcome of that next state.
module player_physics
    import game_pkg::*;
#(
    parameter int CHAR_WIDTH  = 6,
    parameter int CHAR_HEIGHT = 6,
    parameter int SPEED       = 2,
    parameter int JUMP_VEL    = -8,
    parameter int GRAVITY     = 1,
    parameter int MAX_FALL    = 8,
    parameter int WIN_X       = 520
) (
    input  logic              [9:0] x_i,
    input  logic              [9:0] y_i,
    input  logic signed       [5:0] vel_i,
    input  logic                    left_i,
    input  logic                    right_i,
    input  logic                    jump_i,
    output logic              [9:0] x_o,
    output logic              [9:0] y_o,
    output logic signed       [5:0] vel_o,
    output logic                    lava_o,
    output logic                    win_o
);

    localparam logic signed [10:0] CW   = 11'(CHAR_WIDTH);
    localparam logic signed [10:0] CH   = 11'(CHAR_HEIGHT);
    localparam logic signed [10:0] SP   = 11'(SPEED);
    localparam logic signed [10:0] JV   = 11'(JUMP_VEL);
    localparam logic signed [10:0] GR   = 11'(GRAVITY);
    localparam logic signed [10:0] MF   = 11'(MAX_FALL);
    localparam logic signed [10:0] WX   = 11'(WIN_X);
    localparam logic signed [10:0] ZERO = 11'sd0;

    logic signed [10:0] xs, ys, vs;
    logic signed [10:0] x_n, y_n, v;
    logic signed [10:0] land_y;
    logic               grounded, landed, lava;

    always_comb begin
        xs = $signed({1'b0, x_i});
        ys = $signed({1'b0, y_i});
        vs = $signed({{5{vel_i[5]}}, vel_i});

        // Horizontal move. Pressing both directions cancels out.
        x_n = xs;
        if (left_i && !right_i) begin
            x_n = xs - SP;
            if (x_n < ZERO) x_n = ZERO;
        end else if (right_i && !left_i) begin
            x_n = xs + SP;
            if (x_n > (WIDTH - CW)) x_n = WIDTH - CW;
        end

        // Standing test uses the new column but the old height. Walking off
        // an edge therefore starts the fall in the same frame.
        grounded = 1'b0;
        for (int i = 0; i < NUM_PLATS; i++) begin
            if (((ys + CH) == PLATS[i].plat_y) && x_overlap(x_n, CW, PLATS[i]))
                grounded = 1'b1;
        end

        if (grounded && jump_i)  v = JV;
        else if (grounded)       v = ZERO;
        else begin
            v = vs + GR;
            if (v > MF) v = MF;
        end

        y_n = ys + v;

        // Landing only on the way down, when the feet cross a platform top
        // this frame. The first surface crossed (smallest plat_y) wins.
        landed = 1'b0;
        land_y = ZERO;
        if (v > ZERO) begin
            for (int i = 0; i < NUM_PLATS; i++) begin
                if (x_overlap(x_n, CW, PLATS[i]) &&
                    ((ys + CH) <= PLATS[i].plat_y) &&
                    ((y_n + CH) >= PLATS[i].plat_y) &&
                    (!landed || (PLATS[i].plat_y < land_y))) begin
                    landed = 1'b1;
                    land_y = PLATS[i].plat_y;
                end
            end
        end
        if (landed) begin
            y_n = land_y - CH;
            v   = ZERO;
        end

        // Ceiling: a jump that would leave the top of the screen stops there.
        if (y_n < ZERO) begin
            y_n = ZERO;
            v   = ZERO;
        end

        lava = (y_n + CH) > LAVA_LVL;
    end

    assign x_o    = x_n[9:0];
    assign y_o    = y_n[9:0];
    assign vel_o  = v[5:0];
    assign lava_o = lava;
    // Lava beats goal. The goal needs the player standing on platform 3 far enough right.
    assign win_o  = !lava && ((y_n + CH) == PLATS[2].plat_y) &&
                    x_overlap(x_n, CW, PLATS[2]) && (x_n >= WX);

    // The high bits are always zero/sign copies once clamped.
    logic unused_bits;
    assign unused_bits = ^{x_n[10], y_n[10], v[10:6]};

endmodule

// File: rtl/game_controller.sv
// Purpose : game-state FSM (menu/on/lose/win), per-frame player registers and the per-pixel sprite hit.
// Latency : state/position update one clock after frame_tick or the start edge. in_char has zero latency.
// Backpressure: none. Inputs are sampled every clock, and outputs are always valid.
// Ports   : clk, rst (synchronous, active high). bus = game_controller_if slave: buttons,
//           frame_tick and pixel coordinates in; S, char_x, char_y and in_char out.
module game_controller
    import game_pkg::*;
#(
    parameter int CHAR_WIDTH  = 6,
    parameter int CHAR_HEIGHT = 6,
    parameter int SPEED       = 2,
    parameter int JUMP_VEL    = -8,
    parameter int GRAVITY     = 1,
    parameter int MAX_FALL    = 8,
    parameter int START_X     = 100,
    parameter int START_Y     = 419,
    parameter int WIN_X       = 520
) (
    input  logic               clk,
    input  logic               rst,
    game_controller_if.slave   bus
);

    localparam logic [9:0]  START_X_V = 10'(START_X);
    localparam logic [9:0]  START_Y_V = 10'(START_Y);
    localparam logic [10:0] CW_U      = 11'(CHAR_WIDTH);
    localparam logic [10:0] CH_U      = 11'(CHAR_HEIGHT);

    game_state_e        state_q;
    logic         [9:0] x_q, y_q;
    logic signed  [5:0] vel_q;
    logic               start_q;

    logic         [9:0] x_d, y_d;
    logic signed  [5:0] vel_d;
    logic               lava, win;
    logic               start_edge;

    assign start_edge = bus.btn_start && !start_q;

    player_physics #(
        .CHAR_WIDTH  (CHAR_WIDTH),
        .CHAR_HEIGHT (CHAR_HEIGHT),
        .SPEED       (SPEED),
        .JUMP_VEL    (JUMP_VEL),
        .GRAVITY     (GRAVITY),
        .MAX_FALL    (MAX_FALL),
        .WIN_X       (WIN_X)
    ) u_physics (
        .x_i     (x_q),
        .y_i     (y_q),
        .vel_i   (vel_q),
        .left_i  (bus.btn_left),
        .right_i (bus.btn_right),
        .jump_i  (bus.btn_jump),
        .x_o     (x_d),
        .y_o     (y_d),
        .vel_o   (vel_d),
        .lava_o  (lava),
        .win_o   (win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GAME_MENU;
            x_q     <= START_X_V;
            y_q     <= START_Y_V;
            vel_q   <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= bus.btn_start;
            case (state_q)
                // Entering play always respawns. A frame_tick in the same
                // cycle is deliberately not applied.
                GAME_MENU: begin
                    if (start_edge) begin
                        state_q <= GAME_ON;
                        x_q     <= START_X_V;
                        y_q     <= START_Y_V;
                        vel_q   <= '0;
                    end
                end
                GAME_ON: begin
                    if (bus.frame_tick) begin
                        x_q   <= x_d;
                        y_q   <= y_d;
                        vel_q <= vel_d;
                        if (lava)     state_q <= GAME_LOSE;
                        else if (win) state_q <= GAME_WIN;
                    end
                end
                GAME_LOSE, GAME_WIN: begin
                    if (start_edge) state_q <= GAME_MENU;
                end
                default: state_q <= GAME_MENU;
            endcase
        end
    end

    assign bus.S      = state_q;
    assign bus.char_x = x_q;
    assign bus.char_y = y_q;

    // Combinational so the hit stays aligned with the pixel the renderer is drawing.
    assign bus.in_char = (state_q == GAME_ON) &&
                         ({1'b0, bus.x_coord} >= {1'b0, x_q}) &&
                         ({1'b0, bus.x_coord} <  ({1'b0, x_q} + CW_U)) &&
                         ({1'b0, bus.y_coord} >= {1'b0, y_q}) &&
                         ({1'b0, bus.y_coord} <  ({1'b0, y_q} + CH_U));

endmodule
